// File: rtl/i2c_reg_controller.sv
// Byte-level I2C target controller: decodes device address, register pointer
// and data bytes into register-bus write/read requests with a completion pulse.
package i2c_pkg;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       write_en;
    logic       read_en;
  } reg_bus_t;
endpackage

module i2c_reg_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sleep,
  input  logic       start,
  input  logic       stop,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output reg_bus_t   reg_bus,
  output logic       transaction_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    REG    = 3'd2,
    DATA   = 3'd3,
    READ   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] ptr;
  logic [7:0] ptr_next;
  reg_bus_t   bus_next;
  logic       done_next;

  logic addr_match;
  logic byte_ok;
  logic in_txn;

  // A byte counts only when no higher-priority event shares its cycle.
  assign addr_match = (rx_data[7:1] == DEVICE_ADDR);
  assign byte_ok    = rx_valid && !stop && !start && !sleep;
  assign in_txn     = (state == ADDR) || (state == REG) ||
                      (state == DATA) || (state == READ);

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= 8'h00;
      reg_bus          <= '0;
      transaction_done <= 1'b0;
    end else begin
      state            <= next_state;
      ptr              <= ptr_next;
      reg_bus          <= bus_next;
      transaction_done <= done_next;
    end
  end

  // Next-state logic; priority sleep > start > stop > rx_valid.
  always_comb begin
    next_state = state;
    if (sleep) begin
      next_state = IDLE;
    end else if (start) begin
      next_state = ADDR;
    end else if (stop) begin
      next_state = IDLE;
    end else if (rx_valid) begin
      case (state)
        ADDR: begin
          if (!addr_match)     next_state = IGNORE;
          else if (rx_data[0]) next_state = READ;
          else                 next_state = REG;
        end
        REG:     next_state = DATA;
        default: next_state = state;
      endcase
    end
  end

  // Output/datapath next values; addr and data hold between requests.
  always_comb begin
    ptr_next          = ptr;
    bus_next          = reg_bus;
    bus_next.write_en = 1'b0;
    bus_next.read_en  = 1'b0;
    done_next         = 1'b0;
    if (!sleep && !start && stop && in_txn) begin
      done_next = 1'b1;
    end
    if (byte_ok) begin
      case (state)
        ADDR: begin
          if (addr_match && rx_data[0]) begin
            bus_next.addr    = ptr;
            bus_next.read_en = 1'b1;
          end
        end
        REG: ptr_next = rx_data;
        DATA: begin
          bus_next.addr     = ptr;
          bus_next.data     = rx_data;
          bus_next.write_en = 1'b1;
          ptr_next          = ptr + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_controller.sv
// Directed self-checking bench for i2c_reg_controller.
module tb_i2c_reg_controller;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sleep;
  logic       start;
  logic       stop;
  logic       rx_valid;
  logic [7:0] rx_data;
  reg_bus_t   reg_bus;
  logic       transaction_done;

  int pass_cnt = 0;
  int total    = 0;

  int         wr_cnt, rd_cnt, done_cnt, both_cnt;
  logic [7:0] wr_addr [16];
  logic [7:0] wr_data [16];
  logic [7:0] rd_addr;

  i2c_reg_controller #(.DEVICE_ADDR(7'h40)) dut (
    .clk              (clk),
    .reset            (reset),
    .sleep            (sleep),
    .start            (start),
    .stop             (stop),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .reg_bus          (reg_bus),
    .transaction_done (transaction_done)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_bus.write_en) begin
        if (wr_cnt < 16) begin
          wr_addr[wr_cnt] = reg_bus.addr;
          wr_data[wr_cnt] = reg_bus.data;
        end
        wr_cnt++;
      end
      if (reg_bus.read_en) begin
        rd_addr = reg_bus.addr;
        rd_cnt++;
      end
      if (transaction_done) done_cnt++;
      if (reg_bus.write_en && reg_bus.read_en) both_cnt++;
    end
  end

  task automatic cyc(input logic st, input logic sp, input logic rv, input logic [7:0] d);
    @(negedge clk);
    start = st; stop = sp; rx_valid = rv; rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clr;
    @(negedge clk);
    #1;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; both_cnt = 0; rd_addr = 8'h00;
  endtask

  task automatic test_reset;
    sleep = 0; start = 0; stop = 0; rx_valid = 0; rx_data = 8'h00;
    reset = 1;
    repeat (3) @(negedge clk);
    total++;
    if (reg_bus !== 18'h0) $display("FAIL reset_bus got=%h exp=%h", reg_bus, 18'h0);
    else pass_cnt++;
    total++;
    if (transaction_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", transaction_done);
    else pass_cnt++;
    reset = 0;
    clr();
  endtask

  task automatic test_write_pwm0;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'hAA);
    idle(1);
    total++;
    if ({reg_bus.write_en, reg_bus.addr, reg_bus.data} !== {1'b1, 8'h01, 8'hAA})
      $display("FAIL pwm0_latency got we=%b a=%h d=%h exp we=1 a=01 d=aa",
               reg_bus.write_en, reg_bus.addr, reg_bus.data);
    else pass_cnt++;
    idle(1);
    total++;
    if (reg_bus.write_en !== 1'b0) $display("FAIL pwm0_we_width got=%b exp=0", reg_bus.write_en);
    else pass_cnt++;
    cyc(0, 1, 0, 8'h00);
    idle(1);
    total++;
    if (transaction_done !== 1'b1) $display("FAIL pwm0_done_latency got=%b exp=1", transaction_done);
    else pass_cnt++;
    idle(2);
    total++;
    if ({wr_cnt, done_cnt, rd_cnt} !== {32'd1, 32'd1, 32'd0})
      $display("FAIL pwm0_counts got wr=%0d done=%0d rd=%0d exp 1 1 0", wr_cnt, done_cnt, rd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_write_ledout;
    clr();
    cyc(1, 0, 0, 8'h00); idle(1);
    cyc(0, 0, 1, 8'h80); idle(1);
    cyc(0, 0, 1, 8'h07); idle(1);
    cyc(0, 0, 1, 8'h55); idle(1);
    cyc(0, 1, 0, 8'h00); idle(2);
    total++;
    if ({wr_cnt, done_cnt, wr_addr[0], wr_data[0]} !== {32'd1, 32'd1, 8'h07, 8'h55})
      $display("FAIL ledout got wr=%0d done=%0d a=%h d=%h exp 1 1 07 55",
               wr_cnt, done_cnt, wr_addr[0], wr_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'hFE);
    cyc(0, 0, 1, 8'h11);
    idle(1);
    cyc(0, 0, 1, 8'h22);
    idle(1);
    cyc(0, 0, 1, 8'h33);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if (wr_cnt !== 3) $display("FAIL wrap_count got=%0d exp=3", wr_cnt);
    else pass_cnt++;
    total++;
    if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]}
        !== {8'hFE, 8'h11, 8'hFF, 8'h22, 8'h00, 8'h33})
      $display("FAIL wrap_values got %h/%h %h/%h %h/%h exp fe/11 ff/22 00/33",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
    else pass_cnt++;
    total++;
    if (done_cnt !== 1) $display("FAIL wrap_done got=%0d exp=1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_mismatch;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h82);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'hAA);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({wr_cnt, done_cnt, rd_cnt} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL mismatch got wr=%0d done=%0d rd=%0d exp 0 0 0", wr_cnt, done_cnt, rd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_read_rstart;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h05);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h81);
    cyc(0, 0, 1, 8'h99);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({rd_cnt, rd_addr, wr_cnt, done_cnt} !== {32'd1, 8'h05, 32'd0, 32'd1})
      $display("FAIL read_rstart got rd=%0d a=%h wr=%0d done=%0d exp 1 05 0 1",
               rd_cnt, rd_addr, wr_cnt, done_cnt);
    else pass_cnt++;
    total++;
    if (reg_bus.data !== 8'h33) $display("FAIL read_data_hold got=%h exp=33", reg_bus.data);
    else pass_cnt++;
  endtask

  task automatic test_sleep;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h10);
    idle(1);
    sleep = 1;
    cyc(0, 0, 1, 8'h99);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h44);
    idle(1);
    sleep = 0;
    cyc(0, 0, 1, 8'h45);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({wr_cnt, done_cnt} !== {32'd0, 32'd0})
      $display("FAIL sleep_abort got wr=%0d done=%0d exp 0 0", wr_cnt, done_cnt);
    else pass_cnt++;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h20);
    cyc(0, 0, 1, 8'h77);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({wr_cnt, done_cnt, wr_addr[0], wr_data[0]} !== {32'd1, 32'd1, 8'h20, 8'h77})
      $display("FAIL sleep_resume got wr=%0d done=%0d a=%h d=%h exp 1 1 20 77",
               wr_cnt, done_cnt, wr_addr[0], wr_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_stop_with_rx;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h30);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 1, 1, 8'h02);
    idle(2);
    total++;
    if ({wr_cnt, done_cnt, wr_addr[0], wr_data[0]} !== {32'd1, 32'd1, 8'h30, 8'h01})
      $display("FAIL stop_rx got wr=%0d done=%0d a=%h d=%h exp 1 1 30 01",
               wr_cnt, done_cnt, wr_addr[0], wr_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h40);
    cyc(0, 0, 1, 8'hA1);
    cyc(0, 0, 1, 8'hA2);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h50);
    cyc(0, 0, 1, 8'hB0);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]}
        !== {32'd3, 8'h40, 8'hA1, 8'h41, 8'hA2, 8'h50, 8'hB0})
      $display("FAIL b2b_writes got n=%0d %h/%h %h/%h %h/%h exp 3 40/a1 41/a2 50/b0", wr_cnt,
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
    else pass_cnt++;
    total++;
    if (done_cnt !== 2) $display("FAIL b2b_done got=%0d exp=2", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_start_beats_stop;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h60);
    cyc(0, 0, 1, 8'h01);
    cyc(1, 1, 0, 8'h00);
    idle(1);
    cyc(0, 0, 1, 8'h81);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({wr_cnt, rd_cnt, rd_addr, done_cnt} !== {32'd1, 32'd1, 8'h61, 32'd1})
      $display("FAIL start_stop got wr=%0d rd=%0d a=%h done=%0d exp 1 1 61 1",
               wr_cnt, rd_cnt, rd_addr, done_cnt);
    else pass_cnt++;
    total++;
    if (both_cnt !== 0) $display("FAIL exclusive_en got=%0d exp=0", both_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80);
    cyc(0, 0, 1, 8'h70);
    cyc(0, 0, 1, 8'h66);
    @(posedge clk);
    #2 reset = 1;
    #1;
    total++;
    if ({reg_bus, transaction_done} !== 19'h0)
      $display("FAIL reset_mid got bus=%h done=%b exp 0 0", reg_bus, transaction_done);
    else pass_cnt++;
    start = 0; stop = 0; rx_valid = 0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 0;
    clr();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h81);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    total++;
    if ({rd_cnt, rd_addr, done_cnt} !== {32'd1, 8'h00, 32'd1})
      $display("FAIL reset_ptr got rd=%0d a=%h done=%0d exp 1 00 1", rd_cnt, rd_addr, done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; both_cnt = 0; rd_addr = 8'h00;
    test_reset();
    test_write_pwm0();
    test_write_ledout();
    test_wrap();
    test_mismatch();
    test_read_rstart();
    test_sleep();
    test_stop_with_rx();
    test_back_to_back();
    test_start_beats_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/i2c_reg_controller.md
# i2c_reg_controller

Byte-level I2C target (slave) protocol controller. It sits between the I2C bit/byte interface, which supplies START/STOP pulses and received bytes, and the LED driver register file. It decodes the 7-bit device address, register pointer and data bytes, then issues register-bus write or read requests. Each addressed transaction ends with a completion pulse.

## Interface
- Types: `i2c_pkg::reg_bus_t` is a packed struct, MSB first: `addr[7:0]`, `data[7:0]`, `write_en`, `read_en` (18 bits).
- Parameter `DEVICE_ADDR`, default 7'h40: 7-bit I2C address this target responds to.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sleep` in 1: when 1, the block ignores the bus and is held in IDLE.
- `start` in 1: one-cycle pulse on I2C START or repeated START.
- `stop` in 1: one-cycle pulse on I2C STOP.
- `rx_valid` in 1: one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_data` in 8: received byte.
- `reg_bus` out `reg_bus_t`: register-bus request.
- `transaction_done` out 1: one-cycle pulse at the end of an addressed transaction.

## Operation
- States:
  - IDLE
  - ADDR: awaiting address byte
  - REG: awaiting register pointer
  - DATA: awaiting data bytes
  - READ
  - IGNORE: not addressed
- IDLE:
  - `start` -> ADDR.
  - `rx_valid` and `stop` are ignored.
- ADDR, on `rx_valid`:
  - `rx_data[7:1]` == DEVICE_ADDR and `rx_data[0]`=0 -> REG.
  - Address matches and `rx_data[0]`=1 -> READ. `read_en` pulses with `reg_bus.addr` = current register pointer.
  - Address mismatch -> IGNORE.
- REG, on `rx_valid`: register pointer <= `rx_data`; go to DATA.
- DATA, on each `rx_valid`:
  - Issue a write: `reg_bus.addr` = pointer, `reg_bus.data` = `rx_data`, `write_en` pulses.
  - Then pointer <= pointer+1, 8-bit wrap (0xFF -> 0x00).
  - Stay in DATA.
- READ and IGNORE: `rx_valid` is ignored.
- `stop`:
  - From ADDR, REG, DATA or READ: pulse `transaction_done`, go to IDLE.
  - From IGNORE: go to IDLE with no done pulse.
- `start` in any non-IDLE state is a repeated START: go to ADDR, no done pulse, pointer retained.
- Simultaneous events in one cycle, priority order:
  - `sleep` beats everything.
  - `start` beats `stop`.
  - `stop` beats `rx_valid`; the byte is dropped.
- `sleep`=1 mid-transaction: abort to IDLE immediately, no write, no done pulse. Resume normally on the next `start` after `sleep` drops.
- `reg_bus.addr` and `reg_bus.data` hold their last issued values between requests.
- `write_en` and `read_en` are never both 1.

## Timing
- Reset values: state IDLE, pointer 0x00, `reg_bus` all zeros, `transaction_done`=0.
- All outputs are registered.
- Write latency: `write_en`, `addr` and `data` appear in the cycle after the `rx_valid` edge that captured the data byte. `write_en` is high exactly one cycle.
- Read latency: `read_en` is high exactly one cycle, in the cycle after the address byte is sampled.
- `transaction_done` is high exactly one cycle, in the cycle after `stop` is sampled.
- Back-to-back `rx_valid` pulses on consecutive cycles are all accepted.
- No minimum gap is required between `stop` and the next `start`.
- Reset mid-transaction clears to reset values asynchronously; any pending pulse is lost.

## Test plan
- Write PWM0: START, 0x80, 0x01, 0xAA, STOP -> one `write_en` pulse with addr 0x01, data 0xAA; one `transaction_done` pulse.
- Write LEDOUT: START, 0x80, 0x07, 0x55, STOP -> write addr 0x07, data 0x55; done pulse.
- Auto-increment with wrap: START, 0x80, 0xFE, 0x11, 0x22, 0x33, STOP -> writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33).
- Address mismatch: START, 0x82, 0x01, 0xAA, STOP -> no `write_en`, no `transaction_done`.
- Read and repeated START: START, 0x80, 0x05, START, 0x81, STOP -> exactly one `read_en` pulse with addr 0x05; one done pulse.
- Sleep abort and conflicts:
  - `sleep`=1 after the register byte, then data byte and STOP -> no write, no done.
  - `stop` together with `rx_valid` in DATA -> byte dropped, done pulse issued.
